// File: rtl/prescaler_sched.sv
// Round-robin scheduler sharing one N-bit prescaler counter among NCH requesters.
// Optional PRESCALER_SCHED_ABORT_EN: dropping req[owner] during LOAD/RUN aborts the job.
module prescaler_sched #(
  parameter int N   = 20,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*N-1:0] tc_in,
  output logic [NCH-1:0]   grant,
  output logic [NCH-1:0]   done,
  output logic             busy,
  output logic             q,
  output logic [N-1:0]     count
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_owner, w_owner_nxt;
  logic [PW-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [N-1:0]   r_tc, w_tc_nxt;
  logic [N-1:0]   r_count, w_count_nxt;
  logic [NCH-1:0] r_grant, w_grant_nxt;
  logic [NCH-1:0] r_done, w_done_nxt;
  logic           r_q, w_q_nxt;

  logic           w_found;
  logic [PW-1:0]  w_pick;
  logic [PW-1:0]  w_owner_inc;

  // Channel index (base + off) wrapped modulo NCH; off is always below NCH.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NCH)) s = s - 32'(NCH);
    return PW'(s);
  endfunction

  assign w_owner_inc = wrap_add(r_owner, 1);

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && req[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_tc_nxt     = r_tc;
    w_count_nxt  = r_count;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_q_nxt      = r_q;

    unique case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
        w_q_nxt     = 1'b0;
        if (w_found) begin
          w_state_nxt          = S_LOAD;
          w_owner_nxt          = w_pick;
          w_grant_nxt[w_pick]  = 1'b1;
        end
      end

      S_LOAD: begin
        w_tc_nxt    = tc_in[r_owner*N +: N];
        w_count_nxt = '0;
        w_state_nxt = S_RUN;
        // q follows the count it will show next cycle: 0 >= tc/2 only for tc < 2.
        w_q_nxt     = ((w_tc_nxt >> 1) == '0);
      end

      S_RUN: begin
        if (r_count == r_tc) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
        end else begin
          w_count_nxt = r_count + N'(1);
        end
        w_q_nxt = (w_count_nxt >= (r_tc >> 1));
      end

      S_DONE: begin
        w_state_nxt  = S_IDLE;
        w_rr_ptr_nxt = w_owner_inc;
        w_grant_nxt  = '0;
        w_count_nxt  = '0;
        w_q_nxt      = 1'b0;
      end
    endcase

`ifdef PRESCALER_SCHED_ABORT_EN
    // Owner withdrew its request before completion: drop the job silently.
    if ((r_state == S_LOAD || r_state == S_RUN) && !req[r_owner]) begin
      w_state_nxt  = S_IDLE;
      w_rr_ptr_nxt = w_owner_inc;
      w_grant_nxt  = '0;
      w_done_nxt   = '0;
      w_count_nxt  = '0;
      w_q_nxt      = 1'b0;
    end
`else
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_tc     <= '0;
      r_count  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_q      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_tc     <= w_tc_nxt;
      r_count  <= w_count_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_q      <= w_q_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);
  assign q     = r_q;
  assign count = r_count;

endmodule

// File: tb/tb_prescaler_sched.sv
// Scoreboard bench for prescaler_sched: a job-level timing model fills an
// expected per-cycle output timeline and a queue of expected done pulses.
module tb_prescaler_sched;

  localparam int N   = 6;
  localparam int NCH = 4;

  logic             clk;
  logic             reset;
  logic [NCH-1:0]   req;
  logic [NCH*N-1:0] tc_in;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   done;
  logic             busy;
  logic             q;
  logic [N-1:0]     count;

  prescaler_sched #(.N(N), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .tc_in (tc_in),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .q     (q),
    .count (count)
  );

  typedef struct packed {
    logic [NCH-1:0] grant;
    logic [NCH-1:0] done;
    logic           busy;
    logic           q;
    logic [N-1:0]   count;
  } obs_t;

  typedef struct {
    int ch;
    int cyc;
    int tc;
  } job_t;

  obs_t tl[int];      // expected outputs per cycle; absent entry means idle
  job_t exp_q[$];     // expected done pulses in order

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rr_m     = 0;
  bit chk_en   = 0;
  bit stim_end = 0;
  int tcv[NCH];
  int reps[NCH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Job whose req is first sampled at edge t+1: LOAD at t+1, RUN t+2..t+2+tc,
  // DONE at t+3+tc. Outputs vanish from cycle 'cut' onward when cut >= 0.
  task automatic add_job(input int ch, input int tc, input int t, input int cut);
    obs_t o;
    job_t j;
    for (int c = t + 1; c <= t + 3 + tc; c++) begin
      if (cut >= 0 && c >= cut) break;
      o = '0;
      o.grant[ch] = 1'b1;
      o.busy = 1'b1;
      if (c >= t + 2 && c <= t + 2 + tc) begin
        o.count = N'(c - t - 2);
        o.q     = ((c - t - 2) >= tc / 2);
      end else if (c == t + 3 + tc) begin
        o.count    = N'(tc);
        o.q        = 1'b1;
        o.done[ch] = 1'b1;
      end
      tl[c] = o;
    end
    if (cut < 0) begin
      j.ch = ch; j.cyc = t + 3 + tc; j.tc = tc;
      exp_q.push_back(j);
    end
  endtask

  task automatic prune_from(input int c);
    int ks[$];
    foreach (tl[k]) if (k >= c) ks.push_back(k);
    foreach (ks[i]) tl.delete(ks[i]);
  endtask

  // All channels in mask request together; each is served reps[ch] times in
  // rotation and drops its request in the idle cycle after its last done.
  task automatic run_round(input logic [NCH-1:0] mask, input int poke_off, input int poke_val,
                           input int ab_ch, input int ab_off);
    int t0, t, tc, cut, found, ab_cyc, poke_cyc, t_end;
    int left[NCH];
    int drop_at[NCH];
    t0       = cyc;
    ab_cyc   = (ab_ch >= 0) ? t0 + ab_off : -10;
    poke_cyc = (poke_off >= 0) ? t0 + poke_off : -10;
    for (int ch = 0; ch < NCH; ch++) begin
      tc_in[ch*N +: N] = N'(tcv[ch]);
      left[ch]    = mask[ch] ? reps[ch] : 0;
      drop_at[ch] = -10;
    end
    if (ab_ch >= 0) drop_at[ab_ch] = ab_cyc;
    req = mask;
    t = t0;
    forever begin
      found = -1;
      for (int k = 0; k < NCH; k++)
        if (found < 0 && left[(rr_m + k) % NCH] > 0) found = (rr_m + k) % NCH;
      if (found < 0) break;
      tc  = tcv[found];
      cut = -1;
`ifdef PRESCALER_SCHED_ABORT_EN
      if (found == ab_ch && ab_cyc + 1 >= t + 2 && ab_cyc + 1 <= t + 3 + tc) cut = ab_cyc + 1;
`endif
      add_job(found, tc, t, cut);
      rr_m = (found + 1) % NCH;
      if (cut >= 0) begin
        left[found] = 0;
        t = cut;
      end else begin
        left[found]--;
        if (left[found] == 0 && found != ab_ch) drop_at[found] = t + tc + 4;
        t = t + tc + 4;
      end
    end
    t_end = t;
    while (cyc < t_end + 1) begin
      for (int ch = 0; ch < NCH; ch++) if (drop_at[ch] == cyc) req[ch] = 1'b0;
      if (cyc == poke_cyc) tc_in[0 +: N] = N'(poke_val);
      tick();
    end
  endtask

  // Monitor: compares every cycle against the timeline and pops the done queue.
  obs_t mon_a, mon_e;
  job_t mon_j;
  always @(negedge clk) begin
    if (chk_en) begin
      mon_a.grant = grant; mon_a.done = done; mon_a.busy = busy;
      mon_a.q = q; mon_a.count = count;
      mon_e = tl.exists(cyc) ? tl[cyc] : '0;
      check("outputs{grant,done,busy,q,count}", 32'(mon_a), 32'(mon_e));
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done at cycle %0d: got done=%b, expected none", cyc, done);
        end else begin
          mon_j = exp_q.pop_front();
          check("done_channel", 32'(done), 32'(1 << mon_j.ch));
          check("done_cycle", cyc, mon_j.cyc);
          check("done_count", 32'(count), mon_j.tc);
        end
      end
    end
    if (stim_end) begin
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b1;
    req   = '0;
    tc_in = '0;
    for (int ch = 0; ch < NCH; ch++) begin tcv[ch] = 0; reps[ch] = 1; end
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();

    // Single job on channel 0, tc = 9.
    tcv[0] = 9;
    run_round(4'b0001, -1, 0, -1, 0);
    repeat (2) tick();

    // Reset held 3 cycles in the middle of channel 1's run (count = 5).
    tcv[1] = 10;
    tc_in[1*N +: N] = N'(10);
    t0 = cyc;
    req = 4'b0010;
    add_job(1, 10, t0, -1);
    wait_until(t0 + 7);
    reset = 1'b1;
    req   = '0;
    prune_from(cyc + 1);
    exp_q.delete();
    rr_m = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();

    // Round-robin fairness: all request, all tc = 2, order 0,1,2,3,0.
    for (int ch = 0; ch < NCH; ch++) begin tcv[ch] = 2; reps[ch] = 1; end
    reps[0] = 2;
    run_round(4'b1111, -1, 0, -1, 0);
    for (int ch = 0; ch < NCH; ch++) reps[ch] = 1;
    repeat (2) tick();

    // Channel 2 drops req at count = 3 with channel 3 pending.
    tcv[2] = 10; tcv[3] = 3;
    run_round(4'b1100, -1, 0, 2, 5);
    repeat (2) tick();

    // Terminal-count extremes.
    tcv[0] = 0;
    run_round(4'b0001, -1, 0, -1, 0);
    tcv[1] = (1 << N) - 1;
    run_round(4'b0010, -1, 0, -1, 0);

    // tc_in rewritten from 5 to 50 during RUN has no effect.
    tcv[0] = 5;
    run_round(4'b0001, 4, 50, -1, 0);
    repeat (2) tick();

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        tcv[ch]  = ($urandom_range(0, 9) == 0) ? (1 << N) - 1 : int'($urandom_range(0, 20));
        reps[ch] = int'($urandom_range(1, 2));
      end
      run_round(NCH'($urandom_range(1, (1 << NCH) - 1)), -1, 0, -1, 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    stim_end = 1'b1;
  end

endmodule

// File: doc/prescaler_sched.md
# prescaler_sched

Round-robin scheduler that shares one N-bit prescaler counter among NCH requesters. Each requester asks for a timed interval of a programmed length. The block grants the counter to one requester at a time, runs it from 0 to the requester's terminal count, and drives a half-period square wave `q` while running. It signals completion with a one-cycle `done` pulse. It sits between the timing consumers (display multiplexers, debouncers, blink generators) and the shared divide-by-M datapath, replacing per-consumer divider instances.

## Interface
- `N`, 20, counter and terminal-count width
- `NCH`, 4, number of requesters (2..8)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`
- `req`  in  NCH  per-channel request level
- `tc_in`  in  NCH*N  packed terminal counts; channel i at bits [i*N +: N]
- `grant`  out  NCH  one-hot owner of the counter, or all zero
- `done`  out  NCH  one-cycle completion pulse for the owning channel
- `busy`  out  1  high in any state other than IDLE
- `q`  out  1  square wave for the current job; 0 when idle
- `count`  out  N  current counter value, for debug and verification

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any `req` bit is high, pick the first requesting channel at or after `rr_ptr`, wrapping modulo NCH.
  - Move to LOAD and set `grant` one-hot for that channel.
  - If no `req` bit is high, stay in IDLE.
- **LOAD**
  - Latch the winner's `tc_in` slice into internal `tc`.
  - Clear `count` to 0 and go to RUN.
  - Changes to `tc_in` after LOAD have no effect on the running job.
- **RUN**
  - `count` increments by 1 each cycle.
  - When `count == tc`, go to DONE on the next edge; `count` holds at `tc`.
  - `q = 0` while `count < tc/2` (integer floor), else `q = 1`.
- **DONE**
  - `done[owner] = 1` for exactly one cycle; `grant[owner]` stays high this cycle.
  - Set `rr_ptr` to (owner+1) mod NCH, then go to IDLE.
  - `grant`, `q` and `count` clear on entry to IDLE.
- Requesters must hold `req` high until their `done` pulse. A `req` still high after `done` counts as a new request and joins the rotation.
- Arithmetic:
  - `count` and `tc` are N bits; `count` never exceeds `tc`, so no wrap.
  - `tc = 0` gives RUN for exactly 1 cycle with `q = 1`, since 0 < 0 is false.
  - `tc = 2^N-1` is legal.
- Reset values:
  - state IDLE, `grant` 0, `done` 0, `busy` 0, `q` 0, `count` 0, `rr_ptr` 0.
  - Reset asserted in any state returns to these values on the next edge. No `done` is issued for the interrupted job.

## Timing
- `req[i]` first high at edge t, block idle: `grant[i]` at t+1 (LOAD), RUN from t+2 with `count = 0`, `count = tc` at t+2+tc, `done[i]` at t+3+tc, IDLE at t+4+tc.
- Job occupancy is tc+4 cycles, including the IDLE slot.
- Minimum spacing between back-to-back grants is one IDLE cycle.
- `busy` is high from LOAD through DONE inclusive.
- `done` and `grant` are registered outputs. `q` is registered from the next-state `count`, so no combinational path runs from any input to any output.

## Configuration
- `PRESCALER_SCHED_ABORT_EN`
  - Defined: if `req[owner]` is low during LOAD or RUN, the job aborts.
    - Next state is IDLE, no `done` pulse.
    - `rr_ptr` advances past the owner.
    - `grant`, `q` and `count` clear on the next edge.
  - Undefined: `req` is ignored once granted; every granted job runs to DONE.

## Test plan
- Reset behaviour: `reset` held for 3 cycles mid-RUN, channel 1 owner, `tc = 10` -> all outputs 0 the cycle after reset, and no `done[1]` ever appears.
- Single job: `req = 4'b0001`, `tc0 = 9` -> `grant[0]` at t+1, `count` 0..9 over t+2..t+11, `q` low for `count` 0..3 and high for 4..9, `done[0]` at t+12, `busy` low at t+13.
- Round-robin fairness: `req = 4'b1111` held, all `tc = 2` -> grant order 0,1,2,3,0, each `done` 6 cycles apart.
- Edge terminal counts: `tc = 0` -> RUN lasts 1 cycle with `q = 1`, `done` at t+3. `tc = 2^N-1` with N=4 -> RUN lasts 16 cycles and `count` never wraps.
- `tc_in` change: rewrite `tc0` from 5 to 50 during RUN -> job still ends at `count = 5`.
- Abort, with `PRESCALER_SCHED_ABORT_EN` defined: drop `req[2]` at `count = 3`, `req[3]` pending -> no `done[2]`, IDLE then `grant[3]` within 2 cycles. Without the macro, the same stimulus yields `done[2]` at the normal time.
